// File: rtl/control_decoder.sv
// rtl/control_decoder.sv - microinstruction execution stage: fetch, decode and sequence datapath strobes
//
// Sequences each microinstruction through IDLE -> ISSUE -> WAIT_MIR -> LATCH ->
// DRIVE -> [MEM] -> COMMIT -> ISSUE. The next-address field of the committed word
// becomes the new addr. DONE and HALT are terminal until reset.
//
// Optional feature macro: CTRL_DEC_TIMEOUT_EN (bounds the MEM wait by TIMEOUT cycles).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            level start request, only honoured in IDLE
//   mir[29:0]         microinstruction from the control unit
//   finish            end-of-program flag, sampled in LATCH
//   mem_ack           memory completion, sampled in MEM only
//   addr[7:0]         microcode address to the control unit
//   alu_op[3:0]       ALU operation (DRIVE..COMMIT)
//   bus_oe[15:0]      one-hot bus source enable (DRIVE..COMMIT)
//   reg_wen[9:0]      register load strobes (COMMIT pulse)
//   pc_inc            PC increment strobe (COMMIT pulse)
//   imem_rd, dmem_rd, dmem_wr  memory requests (held through MEM)
//   busy              FSM in ISSUE..COMMIT
//   done              program finished
//   err               sticky error (illegal memory code or MEM timeout)

module control_decoder #(
    parameter int MIR_W   = 30,
    parameter int ADDR_W  = 8,
    parameter int MIR_LAT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [MIR_W-1:0]  mir,
    input  logic              finish,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        alu_op,
    output logic [15:0]       bus_oe,
    output logic [9:0]        reg_wen,
    output logic              pc_inc,
    output logic              imem_rd,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    if (MIR_LAT < 1 || MIR_LAT > 7) begin : g_bad_mir_lat
        $error("control_decoder: MIR_LAT must be in 1..7");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("control_decoder: TIMEOUT must be in 1..255");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_MIR,
        S_LATCH,
        S_DRIVE,
        S_MEM,
        S_COMMIT,
        S_DONE,
        S_HALT
    } state_t;

    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_IRD  = 3'b100;
    localparam logic [2:0] MEM_DRD  = 3'b010;
    localparam logic [2:0] MEM_DWR  = 3'b001;

    state_t             state_q, state_d;
    logic [2:0]         wait_cnt_q, wait_cnt_d;
    logic [MIR_W-1:0]   mir_q, mir_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [15:0]        bus_oe_q, bus_oe_d;
    logic [9:0]         reg_wen_q, reg_wen_d;
    logic               pc_inc_q, pc_inc_d;
    logic               imem_rd_q, imem_rd_d;
    logic               dmem_rd_q, dmem_rd_d;
    logic               dmem_wr_q, dmem_wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef CTRL_DEC_TIMEOUT_EN
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;
`endif

    // Word being decoded this cycle. During LATCH the capture register is only
    // being written, so the live mir is used to prime the DRIVE-cycle outputs.
    logic [MIR_W-1:0]   mir_eff;
    logic [ADDR_W-1:0]  f_next;
    logic [3:0]         f_alu;
    logic [9:0]         f_wen;
    logic [2:0]         f_mem;
    logic               f_pc;
    logic [3:0]         f_bus;
    logic               mem_legal;
    logic [15:0]        bus_dec;
    logic               in_exec;

    always_comb begin
        mir_eff   = (state_q == S_LATCH) ? mir : mir_q;
        f_next    = mir_eff[29:22];
        f_alu     = mir_eff[21:18];
        f_wen     = mir_eff[17:8];
        f_mem     = mir_eff[7:5];
        f_pc      = mir_eff[4];
        f_bus     = mir_eff[3:0];
        mem_legal = (f_mem == MEM_NONE) || (f_mem == MEM_IRD) ||
                    (f_mem == MEM_DRD)  || (f_mem == MEM_DWR);
        bus_dec   = 16'h0000;
        if (f_bus != 4'd0) begin
            bus_dec[f_bus] = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mir_d      = mir_q;
        addr_d     = addr_q;
`ifdef CTRL_DEC_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = 3'd0;
                state_d    = S_WAIT_MIR;
            end
            S_WAIT_MIR: begin
                if (wait_cnt_q == 3'(MIR_LAT - 1)) begin
                    state_d = S_LATCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_LATCH: begin
                mir_d = mir;
                // finish outranks an illegal code: the word is never executed
                if (finish) begin
                    state_d = S_DONE;
                end else if (!mem_legal) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (f_mem != MEM_NONE) begin
                    state_d = S_MEM;
`ifdef CTRL_DEC_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_COMMIT;
                end
`ifdef CTRL_DEC_TIMEOUT_EN
                // This ack-less cycle is the one that makes the count hit TIMEOUT
                else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = S_HALT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            S_COMMIT: begin
                addr_d  = f_next;
                state_d = S_ISSUE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered and derived from the state being entered, so each
    // strobe is valid during the cycle its state occupies.
    always_comb begin
        in_exec   = (state_d == S_DRIVE) || (state_d == S_MEM) || (state_d == S_COMMIT);
        alu_op_d  = in_exec ? f_alu : 4'd0;
        bus_oe_d  = in_exec ? bus_dec : 16'h0000;
        reg_wen_d = (state_d == S_COMMIT) ? f_wen : 10'd0;
        pc_inc_d  = (state_d == S_COMMIT) && f_pc;
        imem_rd_d = (state_d == S_MEM) && (f_mem == MEM_IRD);
        dmem_rd_d = (state_d == S_MEM) && (f_mem == MEM_DRD);
        dmem_wr_d = (state_d == S_MEM) && (f_mem == MEM_DWR);
        busy_d    = (state_d == S_ISSUE) || (state_d == S_WAIT_MIR) ||
                    (state_d == S_LATCH) || in_exec;
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 3'd0;
            mir_q      <= '0;
            addr_q     <= '0;
            alu_op_q   <= 4'd0;
            bus_oe_q   <= 16'h0000;
            reg_wen_q  <= 10'd0;
            pc_inc_q   <= 1'b0;
            imem_rd_q  <= 1'b0;
            dmem_rd_q  <= 1'b0;
            dmem_wr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef CTRL_DEC_TIMEOUT_EN
            tmo_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mir_q      <= mir_d;
            addr_q     <= addr_d;
            alu_op_q   <= alu_op_d;
            bus_oe_q   <= bus_oe_d;
            reg_wen_q  <= reg_wen_d;
            pc_inc_q   <= pc_inc_d;
            imem_rd_q  <= imem_rd_d;
            dmem_rd_q  <= dmem_rd_d;
            dmem_wr_q  <= dmem_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef CTRL_DEC_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign addr    = addr_q;
    assign alu_op  = alu_op_q;
    assign bus_oe  = bus_oe_q;
    assign reg_wen = reg_wen_q;
    assign pc_inc  = pc_inc_q;
    assign imem_rd = imem_rd_q;
    assign dmem_rd = dmem_rd_q;
    assign dmem_wr = dmem_wr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_control_decoder.sv
// tb/tb_control_decoder.sv - directed self-checking bench for control_decoder

module tb_control_decoder;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [29:0] mir;
    logic        finish;
    logic        mem_ack;
    logic [7:0]  addr;
    logic [3:0]  alu_op;
    logic [15:0] bus_oe;
    logic [9:0]  reg_wen;
    logic        pc_inc;
    logic        imem_rd;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;

    // Per-cycle samples; index 0 is the ISSUE cycle after enable is seen
    logic [7:0]  s_addr [0:31];
    logic [3:0]  s_alu  [0:31];
    logic [15:0] s_bus  [0:31];
    logic [9:0]  s_wen  [0:31];
    logic        s_pc   [0:31];
    logic        s_ird  [0:31];
    logic        s_drd  [0:31];
    logic        s_dwr  [0:31];
    logic        s_busy [0:31];
    logic        s_done [0:31];
    logic        s_err  [0:31];

    control_decoder #(
        .MIR_W(30), .ADDR_W(8), .MIR_LAT(2), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mir(mir), .finish(finish),
        .mem_ack(mem_ack), .addr(addr), .alu_op(alu_op), .bus_oe(bus_oe),
        .reg_wen(reg_wen), .pc_inc(pc_inc), .imem_rd(imem_rd), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start(input logic [29:0] word, input logic fin);
        rst_n   = 1'b0;
        enable  = 1'b0;
        mem_ack = 1'b0;
        finish  = fin;
        mir     = word;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic run(input int n, input int ack_at, input bit ack_always);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_addr[i] = addr;  s_alu[i] = alu_op; s_bus[i] = bus_oe;
            s_wen[i]  = reg_wen; s_pc[i] = pc_inc; s_ird[i] = imem_rd;
            s_drd[i]  = dmem_rd; s_dwr[i] = dmem_wr; s_busy[i] = busy;
            s_done[i] = done;  s_err[i] = err;
            enable  = 1'b0;
            mem_ack = ack_always || (i == ack_at);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; mir = '0; finish = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        total++;
        if ({addr, alu_op, bus_oe, reg_wen, pc_inc, imem_rd, dmem_rd, dmem_wr, busy, done, err} !== 47'd0) begin
            bad++;
            $display("FAIL reset_outputs got addr=%h alu=%h bus=%h wen=%h flags=%b exp all zero",
                     addr, alu_op, bus_oe, reg_wen, {pc_inc, imem_rd, dmem_rd, dmem_wr, busy, done, err});
        end
    endtask

    task automatic test_no_mem;
        int pulses;
        start({8'h00, 4'b1011, 10'b0000000001, 3'b000, 1'b0, 4'h0}, 1'b0);
        run(8, -1, 1'b0);
        total++;
        if (s_busy[0] !== 1'b1 || s_addr[0] !== 8'h00) begin
            bad++; $display("FAIL nomem_issue got busy=%b addr=%h exp busy=1 addr=00", s_busy[0], s_addr[0]);
        end
        total++;
        if ({s_alu[3], s_alu[4], s_alu[5], s_alu[6]} !== 16'h0BB0) begin
            bad++; $display("FAIL nomem_alu got %h%h%h%h exp 0bb0", s_alu[3], s_alu[4], s_alu[5], s_alu[6]);
        end
        total++;
        if (s_wen[5] !== 10'd1 || s_bus[4] !== 16'h0 || s_bus[5] !== 16'h0) begin
            bad++; $display("FAIL nomem_commit got wen=%h bus=%h/%h exp wen=001 bus=0", s_wen[5], s_bus[4], s_bus[5]);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) if (s_wen[i] != 10'd0) pulses++;
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL nomem_wen_pulse got %0d cycles exp 1", pulses);
        end
        total++;
        if (s_alu[6] !== 4'h0 || s_busy[6] !== 1'b1 || s_addr[6] !== 8'h00) begin
            bad++; $display("FAIL nomem_reissue got alu=%h busy=%b addr=%h exp alu=0 busy=1 addr=00", s_alu[6], s_busy[6], s_addr[6]);
        end
    endtask

    task automatic test_mem_read;
        int hi;
        start({8'h04, 4'h0, 10'h000, 3'b010, 1'b0, 4'h0}, 1'b0);
        run(12, 8, 1'b0);
        hi = 0;
        for (int i = 0; i < 12; i++) if (s_drd[i]) hi++;
        total++;
        if (hi !== 4 || s_drd[5] !== 1'b1 || s_drd[8] !== 1'b1 || s_drd[9] !== 1'b0) begin
            bad++; $display("FAIL read_len got %0d cycles (d5=%b d8=%b d9=%b) exp 4 cycles i5..i8", hi, s_drd[5], s_drd[8], s_drd[9]);
        end
        total++;
        if (s_ird[6] !== 1'b0 || s_dwr[6] !== 1'b0 || s_busy[7] !== 1'b1) begin
            bad++; $display("FAIL read_other got ird=%b dwr=%b busy=%b exp 0 0 1", s_ird[6], s_dwr[6], s_busy[7]);
        end
        total++;
        if (s_addr[9] !== 8'h00 || s_addr[10] !== 8'h04) begin
            bad++; $display("FAIL read_addr got commit=%h issue=%h exp 00 04", s_addr[9], s_addr[10]);
        end
    endtask

    task automatic test_illegal;
        start({8'h05, 4'h7, 10'h3FF, 3'b110, 1'b1, 4'h2}, 1'b0);
        run(10, -1, 1'b0);
        total++;
        if (s_err[4] !== 1'b1 || s_err[9] !== 1'b1 || s_busy[4] !== 1'b0 || s_done[9] !== 1'b0) begin
            bad++; $display("FAIL illegal_halt got err=%b/%b busy=%b done=%b exp 1/1 0 0", s_err[4], s_err[9], s_busy[4], s_done[9]);
        end
        total++;
        if ({s_alu[4], s_bus[4], s_wen[4], s_pc[4], s_ird[4], s_drd[4], s_dwr[4], s_addr[9]} !== 42'd0) begin
            bad++; $display("FAIL illegal_strobes got alu=%h bus=%h wen=%h addr=%h exp all zero", s_alu[4], s_bus[4], s_wen[4], s_addr[9]);
        end
        start({8'h05, 4'h7, 10'h3FF, 3'b110, 1'b1, 4'h2}, 1'b1);
        run(10, -1, 1'b0);
        total++;
        if (s_done[4] !== 1'b1 || s_done[9] !== 1'b1 || s_err[9] !== 1'b0 || s_busy[9] !== 1'b0) begin
            bad++; $display("FAIL finish_priority got done=%b/%b err=%b busy=%b exp 1/1 0 0", s_done[4], s_done[9], s_err[9], s_busy[9]);
        end
        total++;
        if ({s_alu[4], s_wen[4], s_pc[4], s_addr[9]} !== 23'd0) begin
            bad++; $display("FAIL finish_strobes got alu=%h wen=%h pc=%b addr=%h exp all zero", s_alu[4], s_wen[4], s_pc[4], s_addr[9]);
        end
    endtask

    task automatic test_mem_wait;
        start({8'h00, 4'h0, 10'h000, 3'b001, 1'b0, 4'h0}, 1'b0);
        run(12, -1, 1'b0);
`ifdef CTRL_DEC_TIMEOUT_EN
        total++;
        if ({s_dwr[4], s_dwr[5], s_dwr[6], s_dwr[7], s_dwr[8], s_dwr[9]} !== 6'b011110) begin
            bad++; $display("FAIL timeout_req got %b%b%b%b%b%b exp 011110", s_dwr[4], s_dwr[5], s_dwr[6], s_dwr[7], s_dwr[8], s_dwr[9]);
        end
        total++;
        if (s_err[8] !== 1'b0 || s_err[9] !== 1'b1 || s_busy[9] !== 1'b0) begin
            bad++; $display("FAIL timeout_err got err=%b/%b busy=%b exp 0/1 0", s_err[8], s_err[9], s_busy[9]);
        end
`else
        for (int i = 0; i < 1000; i++) @(negedge clk);
        total++;
        if (dmem_wr !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || reg_wen !== 10'd0) begin
            bad++; $display("FAIL mem_wait got dwr=%b busy=%b err=%b wen=%h exp 1 1 0 000", dmem_wr, busy, err, reg_wen);
        end
`endif
    endtask

    task automatic test_pc_bus_back_to_back;
        int pulses;
        start({8'h01, 4'h0, 10'h000, 3'b000, 1'b1, 4'h3}, 1'b0);
        // mem_ack held high throughout: it must have no effect outside MEM
        run(14, -1, 1'b1);
        total++;
        if (s_bus[4] !== 16'h0008 || s_bus[5] !== 16'h0008 || s_bus[6] !== 16'h0000) begin
            bad++; $display("FAIL bus_sel got %h/%h/%h exp 0008/0008/0000", s_bus[4], s_bus[5], s_bus[6]);
        end
        pulses = 0;
        for (int i = 0; i < 14; i++) if (s_pc[i]) pulses++;
        total++;
        if (s_pc[5] !== 1'b1 || s_pc[11] !== 1'b1 || pulses !== 2) begin
            bad++; $display("FAIL pc_inc got c5=%b c11=%b count=%0d exp 1 1 2", s_pc[5], s_pc[11], pulses);
        end
        total++;
        if (s_addr[5] !== 8'h00 || s_addr[6] !== 8'h01 || s_addr[13] !== 8'h01) begin
            bad++; $display("FAIL pc_addr got %h/%h/%h exp 00/01/01", s_addr[5], s_addr[6], s_addr[13]);
        end
    endtask

    task automatic test_reset_mid_run;
        start({8'h04, 4'h9, 10'h000, 3'b010, 1'b0, 4'h5}, 1'b0);
        run(16, 8, 1'b0);
        total++;
        if (s_drd[15] !== 1'b1 || s_addr[15] !== 8'h04 || s_alu[15] !== 4'h9) begin
            bad++; $display("FAIL midrun_pre got drd=%b addr=%h alu=%h exp 1 04 9", s_drd[15], s_addr[15], s_alu[15]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({addr, alu_op, bus_oe, reg_wen, pc_inc, imem_rd, dmem_rd, dmem_wr, busy, done, err} !== 47'd0) begin
            bad++; $display("FAIL midrun_reset got addr=%h alu=%h bus=%h flags=%b exp all zero",
                            addr, alu_op, bus_oe, {pc_inc, imem_rd, dmem_rd, dmem_wr, busy, done, err});
        end
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        total++;
        if (busy !== 1'b1 || addr !== 8'h00 || dmem_rd !== 1'b0) begin
            bad++; $display("FAIL midrun_restart got busy=%b addr=%h drd=%b exp 1 00 0", busy, addr, dmem_rd);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_no_mem();
        test_mem_read();
        test_illegal();
        test_mem_wait();
        test_pc_bus_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
